// File: rtl/dma_io_peripheral.sv
// ---------------------------------------------------------------------------
// dma_io_peripheral
//
// The device end of a DMA channel handshake. It requests service on DREQ,
// waits for DACK, and then moves one byte per completed I/O strobe:
//   - DIR=1 (device-to-memory): bytes come out of a local TX FIFO onto
//     DB_OUT during IOR_N.
//   - DIR=0 (memory-to-device): bytes on DB_IN during IOW_N are captured
//     into a local RX FIFO.
// Single mode gives one byte per request. Demand mode keeps the channel
// for as long as the FIFO can keep transferring. EOP_N ends the grant early.
//
// Ports
//   CLK, RESET           clock; asynchronous active-high reset
//   DREQ                 registered request, high in REQ and ACK
//   DACK                 acknowledge from the controller
//   IOR_N, IOW_N, EOP_N  active-low bus strobes and terminal count
//   DB_IN                bus data captured on IOW_N
//   DB_OUT, DB_OE        TX FIFO head and its bus output enable
//   MODE_DEMAND, DIR     transfer mode and direction, sampled in IDLE
//   TX_WR_EN, TX_DATA    local push into the TX FIFO
//   TX_FULL              TX FIFO full
//   RX_RD_EN             local pop from the RX FIFO
//   RX_DATA              registered byte from the last RX pop
//   RX_EMPTY             RX FIFO empty
//   TC_SEEN              one-cycle pulse when EOP_N ends a grant
//   ERR                  sticky wrong-direction strobe flag
// ---------------------------------------------------------------------------
module dma_io_peripheral #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  output logic          DREQ,
  input  logic          DACK,
  input  logic          IOR_N,
  input  logic          IOW_N,
  input  logic          EOP_N,
  input  logic [DW-1:0] DB_IN,
  output logic [DW-1:0] DB_OUT,
  output logic          DB_OE,
  input  logic          MODE_DEMAND,
  input  logic          DIR,
  input  logic          TX_WR_EN,
  input  logic [DW-1:0] TX_DATA,
  output logic          TX_FULL,
  input  logic          RX_RD_EN,
  output logic [DW-1:0] RX_DATA,
  output logic          RX_EMPTY,
  output logic          TC_SEEN,
  output logic          ERR
);

  localparam logic [AW-1:0] PtrOne   = AW'(1);
  localparam logic [AW:0]   CntOne   = (AW + 1)'(1);
  localparam logic [AW:0]   DepthCnt = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StAck,
    StRecover
  } state_e;

  state_e state_q, state_d;

  // Transfer attributes, frozen for the whole request/grant sequence.
  logic dir_q;
  logic demand_q;

  // Registered strobes for rising-edge (end of strobe) detection.
  logic ior_q;
  logic iow_q;
  // DB_IN as seen in the most recent cycle with IOW_N low.
  logic [DW-1:0] db_in_q;

  logic          dreq_q, dreq_d;
  logic          tc_q, tc_d;
  logic          err_q;
  logic [DW-1:0] rx_data_q;

  // ------------------------------------------------------------------------
  // FIFO storage and bookkeeping
  // ------------------------------------------------------------------------
  logic [DW-1:0] tx_mem [DEPTH];
  logic [AW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [AW:0]   tx_cnt_q, tx_cnt_d;

  logic [DW-1:0] rx_mem [DEPTH];
  logic [AW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [AW:0]   rx_cnt_q, rx_cnt_d;

  logic tx_empty, tx_full;
  logic rx_empty, rx_full;
  logic tx_push, tx_pop;
  logic rx_push, rx_pop;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == DepthCnt);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == DepthCnt);

  // ------------------------------------------------------------------------
  // Strobe completion
  // ------------------------------------------------------------------------
  logic done_tx, done_rx, done;

  assign done_tx = DACK & dir_q & ~ior_q & IOR_N;
  assign done_rx = DACK & ~dir_q & ~iow_q & IOW_N;
  assign done    = dir_q ? done_tx : done_rx;

  assign tx_push = TX_WR_EN & ~tx_full;
  assign tx_pop  = done_tx & ~tx_empty;
  assign rx_push = done_rx & ~rx_full;
  assign rx_pop  = RX_RD_EN & ~rx_empty;

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop) begin
      tx_cnt_d = tx_cnt_q + CntOne;
    end else if (!tx_push && tx_pop) begin
      tx_cnt_d = tx_cnt_q - CntOne;
    end
  end

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop) begin
      rx_cnt_d = rx_cnt_q + CntOne;
    end else if (!rx_push && rx_pop) begin
      rx_cnt_d = rx_cnt_q - CntOne;
    end
  end

  // ------------------------------------------------------------------------
  // Readiness
  // ------------------------------------------------------------------------
  // In IDLE the direction is still being sampled, so use the live input;
  // the registered copy would lag by one cycle.
  logic dir_eff;
  logic ready_now;
  logic ready_next;

  assign dir_eff    = (state_q == StIdle) ? DIR : dir_q;
  assign ready_now  = dir_eff ? !tx_empty : !rx_full;
  // Whether another transfer fits once this cycle's push/pop has landed.
  assign ready_next = dir_q ? (tx_cnt_d != '0) : (rx_cnt_d != DepthCnt);

  // ------------------------------------------------------------------------
  // Request FSM
  // ------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    tc_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (ready_now) begin
          state_d = StReq;
        end
      end
      StReq: begin
        if (DACK) begin
          state_d = StAck;
        end
      end
      StAck: begin
        if (!EOP_N && DACK) begin
          // Any transfer completing this cycle still happens via done.
          state_d = StRecover;
          tc_d    = 1'b1;
        end else if (done) begin
          if (demand_q && ready_next) begin
            state_d = StAck;
          end else begin
            state_d = StRecover;
          end
        end else if (!DACK) begin
          // Preempted: keep requesting.
          state_d = StReq;
        end
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign dreq_d = (state_d == StReq) || (state_d == StAck);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      dreq_q   <= 1'b0;
      tc_q     <= 1'b0;
      dir_q    <= 1'b0;
      demand_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dreq_q  <= dreq_d;
      tc_q    <= tc_d;
      if (state_q == StIdle) begin
        dir_q    <= DIR;
        demand_q <= MODE_DEMAND;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Strobe history, bus capture and error flag
  // ------------------------------------------------------------------------
  logic wrong_strobe;

  assign wrong_strobe = DACK & ((dir_q & ~IOW_N) | (~dir_q & ~IOR_N));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ior_q   <= 1'b1;
      iow_q   <= 1'b1;
      db_in_q <= '0;
      err_q   <= 1'b0;
    end else begin
      ior_q <= IOR_N;
      iow_q <= IOW_N;
      if (!IOW_N) begin
        db_in_q <= DB_IN;
      end
      if (wrong_strobe) begin
        err_q <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // TX FIFO
  // ------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (tx_push) begin
      tx_mem[tx_wr_ptr_q] <= TX_DATA;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      if (tx_push) begin
        tx_wr_ptr_q <= tx_wr_ptr_q + PtrOne;
      end
      if (tx_pop) begin
        tx_rd_ptr_q <= tx_rd_ptr_q + PtrOne;
      end
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // ------------------------------------------------------------------------
  // RX FIFO
  // ------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (rx_push) begin
      rx_mem[rx_wr_ptr_q] <= db_in_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      rx_data_q   <= '0;
    end else begin
      if (rx_push) begin
        rx_wr_ptr_q <= rx_wr_ptr_q + PtrOne;
      end
      if (rx_pop) begin
        rx_rd_ptr_q <= rx_rd_ptr_q + PtrOne;
        rx_data_q   <= rx_mem[rx_rd_ptr_q];
      end
      rx_cnt_q <= rx_cnt_d;
    end
  end

  // ------------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------------
  // An empty FIFO shows zero rather than stale storage.
  assign DB_OUT   = tx_empty ? '0 : tx_mem[tx_rd_ptr_q];
  assign DB_OE    = DACK & ~IOR_N & dir_q & (state_q == StAck);
  assign DREQ     = dreq_q;
  assign TX_FULL  = tx_full;
  assign RX_EMPTY = rx_empty;
  assign RX_DATA  = rx_data_q;
  assign TC_SEEN  = tc_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_dma_io_peripheral.sv
module tb_dma_io_peripheral;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          CLK;
  logic          RESET;
  logic          DREQ;
  logic          DACK;
  logic          IOR_N;
  logic          IOW_N;
  logic          EOP_N;
  logic [DW-1:0] DB_IN;
  logic [DW-1:0] DB_OUT;
  logic          DB_OE;
  logic          MODE_DEMAND;
  logic          DIR;
  logic          TX_WR_EN;
  logic [DW-1:0] TX_DATA;
  logic          TX_FULL;
  logic          RX_RD_EN;
  logic [DW-1:0] RX_DATA;
  logic          RX_EMPTY;
  logic          TC_SEEN;
  logic          ERR;

  dma_io_peripheral #(.DW(DW), .DEPTH(DEPTH)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DREQ        (DREQ),
    .DACK        (DACK),
    .IOR_N       (IOR_N),
    .IOW_N       (IOW_N),
    .EOP_N       (EOP_N),
    .DB_IN       (DB_IN),
    .DB_OUT      (DB_OUT),
    .DB_OE       (DB_OE),
    .MODE_DEMAND (MODE_DEMAND),
    .DIR         (DIR),
    .TX_WR_EN    (TX_WR_EN),
    .TX_DATA     (TX_DATA),
    .TX_FULL     (TX_FULL),
    .RX_RD_EN    (RX_RD_EN),
    .RX_DATA     (RX_DATA),
    .RX_EMPTY    (RX_EMPTY),
    .TC_SEEN     (TC_SEEN),
    .ERR         (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: FIFO contents as plain queues.
  logic [7:0] tx_m[$];
  logic [7:0] rx_m[$];
  logic [7:0] rx_last;
  // Scoreboard queues consumed by the monitor.
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  int n_cmp  = 0;
  int n_bad  = 0;
  int tc_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dreq(input string name);
    int i;
    i = 0;
    while (!DREQ && i < 20) begin
      step();
      i++;
    end
    chk(name, DREQ, 1);
  endtask

  task automatic tx_push(input logic [7:0] d);
    TX_WR_EN = 1'b1;
    TX_DATA  = d;
    if (tx_m.size() < DEPTH) tx_m.push_back(d);
    step();
    TX_WR_EN = 1'b0;
    chk("tx_full", TX_FULL, tx_m.size() == DEPTH);
  endtask

  task automatic rx_pop();
    RX_RD_EN = 1'b1;
    if (rx_m.size() > 0) begin
      rx_last = rx_m.pop_front();
      exp_rx.push_back(rx_last);
      step();
    end else begin
      step();
      chk("rx_hold_on_empty", RX_DATA, rx_last);
    end
    RX_RD_EN = 1'b0;
    chk("rx_empty", RX_EMPTY, rx_m.size() == 0);
  endtask

  // One grant serving TX bytes; in demand mode it runs until the model drains.
  task automatic tx_xfer(input bit demand, input bit preempt, input bit allow_push);
    bit         more;
    int         len;
    int         pushes;
    logic [7:0] d;
    pushes = 0;
    wait_dreq("tx_dreq_wait");
    DACK = 1'b1;
    step();
    if (preempt) begin
      DACK = 1'b0;
      repeat (2) begin
        step();
        chk("preempt_dreq_held", DREQ, 1);
      end
      DACK = 1'b1;
      step();
    end
    do begin
      exp_tx.push_back(tx_m.pop_front());
      len   = $urandom_range(1, 3);
      IOR_N = 1'b0;
      repeat (len) step();
      IOR_N = 1'b1;
      if (allow_push && pushes < 6 && ($urandom % 3) == 0) begin
        d        = 8'($urandom);
        TX_WR_EN = 1'b1;
        TX_DATA  = d;
        // The DUT still counts the byte being popped when judging full.
        if (tx_m.size() + 1 < DEPTH) tx_m.push_back(d);
        pushes++;
      end
      step();
      TX_WR_EN = 1'b0;
      more = demand && (tx_m.size() > 0);
      chk("tx_dreq_after_done", DREQ, more);
    end while (more);
    DACK = 1'b0;
    step();
    chk("tx_dreq_gap", DREQ, 0);
    step();
    chk("tx_dreq_rerise", DREQ, tx_m.size() > 0);
  endtask

  task automatic rx_single(input bit last);
    logic [7:0] v;
    int         len;
    v   = 8'($urandom);
    len = $urandom_range(1, 3);
    wait_dreq("rx_dreq_wait");
    DACK = 1'b1;
    step();
    DB_IN = v;
    IOW_N = 1'b0;
    repeat (len) step();
    IOW_N = 1'b1;
    DB_IN = 8'($urandom);
    step();
    rx_m.push_back(v);
    chk("rx_dreq_drop", DREQ, 0);
    DACK = 1'b0;
    if (last) DIR = 1'b1;
    step();
    chk("rx_dreq_gap", DREQ, 0);
    step();
    chk("rx_dreq_rerise", DREQ, !last && rx_m.size() < DEPTH);
  endtask

  // Monitor: compares bus bytes and popped RX bytes against the scoreboard.
  initial begin
    logic       prev_oe;
    logic       rd;
    logic [7:0] e;
    prev_oe = 1'b0;
    forever begin
      @(posedge CLK);
      rd = RX_RD_EN;
      @(negedge CLK);
      if (DB_OE && !prev_oe) begin
        if (exp_tx.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL db_oe_unexpected: got DB_OE=1 DB_OUT=%0h expected no drive", DB_OUT);
        end else begin
          e = exp_tx.pop_front();
          chk("db_out", DB_OUT, e);
        end
      end
      prev_oe = DB_OE;
      if (rd && exp_rx.size() > 0) begin
        e = exp_rx.pop_front();
        chk("rx_data", RX_DATA, e);
      end
      if (TC_SEEN) tc_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tc0;
    int n;
    int k;
    RESET = 1'b1; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
    DB_IN = '0; MODE_DEMAND = 1'b0; DIR = 1'b1; TX_WR_EN = 1'b0; TX_DATA = '0;
    RX_RD_EN = 1'b0; rx_last = '0;
    #12;
    chk("rst_dreq", DREQ, 0);
    chk("rst_db_oe", DB_OE, 0);
    chk("rst_db_out", DB_OUT, 0);
    chk("rst_rx_data", RX_DATA, 0);
    chk("rst_tc", TC_SEEN, 0);
    chk("rst_err", ERR, 0);
    chk("rst_tx_full", TX_FULL, 0);
    chk("rst_rx_empty", RX_EMPTY, 1);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Reset in the middle of a grant with three bytes queued.
    for (int i = 0; i < 3; i++) tx_push(8'($urandom));
    wait_dreq("pre_reset_dreq");
    DACK = 1'b1;
    step();
    #2 RESET = 1'b1;
    #1;
    chk("midrst_dreq", DREQ, 0);
    chk("midrst_db_oe", DB_OE, 0);
    chk("midrst_tx_full", TX_FULL, 0);
    chk("midrst_rx_empty", RX_EMPTY, 1);
    tx_m.delete();
    @(posedge CLK); #1;
    RESET = 1'b0;
    DACK  = 1'b0;
    repeat (4) begin
      step();
      chk("postrst_no_dreq", DREQ, 0);
    end
    tx_push(8'h5A);
    tx_xfer(0, 0, 0);

    // Single-mode TX.
    tx_push(8'hA5);
    tx_push(8'h3C);
    tx_xfer(0, 0, 0);
    tx_xfer(0, 0, 0);
    repeat (3) begin
      step();
      chk("tx_drained_no_dreq", DREQ, 0);
    end

    // Demand-mode RX fill to full.
    MODE_DEMAND = 1'b1;
    DIR         = 1'b0;
    wait_dreq("rxd_dreq_wait");
    DACK = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) begin
      DB_IN = 8'(8'h10 + i);
      IOW_N = 1'b0;
      repeat ($urandom_range(1, 2)) step();
      IOW_N = 1'b1;
      DB_IN = 8'($urandom);
      step();
      rx_m.push_back(8'(8'h10 + i));
      chk("rxd_dreq", DREQ, i < DEPTH - 1);
    end
    DACK = 1'b0;
    DIR  = 1'b1;
    step();
    chk("rxd_not_empty", RX_EMPTY, 0);
    repeat (DEPTH) rx_pop();
    rx_pop();

    // EOP during the second strobe of a demand TX grant.
    MODE_DEMAND = 1'b1;
    for (int i = 0; i < 4; i++) tx_push(8'($urandom));
    wait_dreq("eop_dreq_wait");
    DACK = 1'b1;
    step();
    exp_tx.push_back(tx_m.pop_front());
    IOR_N = 1'b0;
    step();
    IOR_N = 1'b1;
    step();
    chk("eop_dreq_after_first", DREQ, 1);
    tc0 = tc_cnt;
    exp_tx.push_back(tx_m.pop_front());
    IOR_N = 1'b0;
    EOP_N = 1'b0;
    step();
    chk("eop_dreq_fall", DREQ, 0);
    chk("eop_tc", TC_SEEN, 1);
    IOR_N = 1'b1;
    EOP_N = 1'b1;
    step();
    chk("eop_dreq_low", DREQ, 0);
    DACK = 1'b0;
    step();
    chk("eop_dreq_rerise", DREQ, 1);
    chk("eop_tc_once", tc_cnt - tc0, 1);
    tx_xfer(1, 1, 0);

    // Explicit preemption in single mode.
    MODE_DEMAND = 1'b0;
    tx_push(8'($urandom));
    tx_push(8'($urandom));
    tx_xfer(0, 1, 0);
    tx_xfer(0, 0, 0);

    // Randomized mix of TX grants and RX single transfers.
    for (int it = 0; it < 20; it++) begin
      MODE_DEMAND = 1'($urandom);
      DIR         = 1'b1;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) tx_push(8'($urandom));
      while (tx_m.size() > 0) tx_xfer(MODE_DEMAND, ($urandom % 4) == 0, 1);
      MODE_DEMAND = 1'b0;
      DIR         = 1'b0;
      k = $urandom_range(1, 3);
      for (int j = 0; j < k; j++) rx_single(j == k - 1);
      while (rx_m.size() > 0) rx_pop();
      if (($urandom % 2) == 0) rx_pop();
    end
    chk("err_clear_before", ERR, 0);

    // Wrong-direction strobe under DACK.
    MODE_DEMAND = 1'b0;
    DIR         = 1'b1;
    tx_push(8'($urandom));
    tx_push(8'($urandom));
    wait_dreq("err_dreq_wait");
    DACK = 1'b1;
    step();
    IOW_N = 1'b0;
    step();
    IOW_N = 1'b1;
    step();
    chk("err_set", ERR, 1);
    chk("err_dreq_held", DREQ, 1);
    chk("err_tx_full", TX_FULL, 0);
    tx_xfer(0, 0, 0);
    tx_xfer(0, 0, 0);
    chk("err_sticky", ERR, 1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
    chk("err_cleared_by_reset", ERR, 0);

    repeat (3) step();
    chk("sb_tx_drained", exp_tx.size(), 0);
    chk("sb_rx_drained", exp_rx.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dma_io_peripheral.md
Name: dma_io_peripheral

Overview:
- Bus-functional I/O peripheral on the device side of the DMA channel handshake.
- Raises DREQ, waits for DACK, then completes byte transfers on IOR_N (device-to-memory) or IOW_N (memory-to-device) strobes.
- Buffers bytes in local TX/RX FIFOs and honours EOP_N termination.
- Serves as the responder end for the DMA controller in integration benches and as a synthesizable peripheral front-end.

Parameters:
- DW, 8, data bus width.
- DEPTH, 8, entries per FIFO; power of two, at least 2.
- AW, $clog2(DEPTH), FIFO pointer width.

Ports:
- CLK  input  1  single clock; all logic on posedge.
- RESET  input  1  asynchronous, active-high reset.
- DREQ  output  1  DMA request to controller, registered.
- DACK  input  1  DMA acknowledge for this channel, active high.
- IOR_N  input  1  I/O read strobe, active low; device drives data.
- IOW_N  input  1  I/O write strobe, active low; device captures data.
- EOP_N  input  1  end of process, active low.
- DB_IN  input  DW  data bus from memory during IOW_N.
- DB_OUT  output  DW  data to bus during IOR_N.
- DB_OE  output  1  output enable for DB_OUT.
- MODE_DEMAND  input  1  0 = single mode, 1 = demand mode; sampled in IDLE.
- DIR  input  1  1 = device-to-memory (TX), 0 = memory-to-device (RX); sampled in IDLE.
- TX_WR_EN  input  1  local push into TX FIFO.
- TX_DATA  input  DW  local push data.
- TX_FULL  output  1  TX FIFO full.
- RX_RD_EN  input  1  local pop from RX FIFO.
- RX_DATA  output  DW  popped RX byte, registered.
- RX_EMPTY  output  1  RX FIFO empty.
- TC_SEEN  output  1  one-cycle pulse when EOP_N is sampled low under DACK.
- ERR  output  1  sticky flag: wrong-direction strobe seen under DACK.

Behaviour:
- Reset values:
  - DREQ=0, DB_OE=0, DB_OUT=0, RX_DATA=0, TC_SEEN=0, ERR=0.
  - Both FIFOs empty: TX_FULL=0, RX_EMPTY=1.
  - State = IDLE.
- Reset asserted mid-transfer aborts everything immediately, including FIFO contents.
- ready:
  - Latched DIR=1: TX count >= 1.
  - Latched DIR=0: RX count < DEPTH.
- Strobe completion (done) is edge-based on registered copies of the strobes:
  - Latched DIR=1: IOR_N previous=0, current=1, with DACK=1.
  - Latched DIR=0: IOW_N previous=0, current=1, with DACK=1.
- Each done performs exactly one transfer:
  - TX: pop the head.
  - RX: push the DB_IN value sampled in the last cycle IOW_N was low.
- FSM states: IDLE, REQ, ACK, RECOVER. DREQ is a registered output that is 1 exactly while state is REQ or ACK.
- IDLE: latch DIR and MODE_DEMAND. If ready, go to REQ next cycle; DREQ rises 1 cycle after ready.
- REQ: hold DREQ. On DACK=1 go to ACK. No timeout.
- ACK, checked in priority order:
  - EOP_N=0 with DACK=1: go to RECOVER and pulse TC_SEEN. A done in the same cycle still transfers.
  - done in single mode: go to RECOVER.
  - done in demand mode: stay in ACK if ready still holds after this transfer, else go to RECOVER.
  - DACK=0 without done (preemption): go back to REQ; DREQ stays high.
- RECOVER: DREQ=0 for exactly 1 cycle, then IDLE. Minimum DREQ low gap is 2 cycles.
- DB_OUT = TX head. DB_OE = DACK & ~IOR_N & latched DIR & (state==ACK).
- ERR: set to 1 when IOW_N=0 under DACK with DIR=1, or IOR_N=0 under DACK with DIR=0. Cleared only by RESET. The wrong-direction strobe is otherwise ignored.
- TX FIFO:
  - Push ignored when full.
  - Simultaneous local push and bus pop both take effect; count is unchanged.
  - Wrap-around via AW-bit pointers plus a count of AW+1 bits.
- RX FIFO:
  - RX_RD_EN with RX_EMPTY=0 updates RX_DATA next cycle.
  - RX_RD_EN with RX_EMPTY=1 is ignored; RX_DATA holds.
  - Simultaneous bus push and local pop both take effect.
- Changes on DIR or MODE_DEMAND outside IDLE have no effect.

Test Plan:
- Reset: assert RESET mid-ACK with 3 TX bytes. Expect DREQ=0, DB_OE=0, TX_FULL=0, RX_EMPTY=1 in the same cycle, and no DREQ until a new push.
- Single-mode TX: push 0xA5, 0x3C; DIR=1; DACK with one IOR_N low pulse per request.
  - DB_OUT=0xA5 then 0x3C during the strobes.
  - DREQ drops 1 cycle after each IOR_N rise and re-rises after a 2-cycle low gap.
  - DREQ stays 0 after the FIFO drains.
- Demand-mode RX: DIR=0, MODE_DEMAND=1, DACK held, 8 IOW_N pulses with DB_IN=0x10..0x17.
  - DREQ stays high through the 7th transfer and drops after the 8th (full).
  - RX_DATA pops 0x10..0x17 in order.
- EOP: demand TX with 4 bytes; EOP_N low during the 2nd IOR_N.
  - TC_SEEN pulses once; 2 bytes popped; DREQ falls.
  - DREQ re-rises 2 cycles later because 2 bytes remain.
- Preemption: DACK drops in ACK without a strobe. Expect DREQ held at 1 and a return to ACK on the next DACK, with no byte lost.
- Error: DIR=1, pulse IOW_N under DACK. Expect ERR=1 sticky, TX count unchanged, ERR cleared only by RESET.
